enemy_missile_spawner: RTL

Downstream consumer of the enemy-missile pseudo-random bit stream. It paces enemy launches on frame ticks and assembles a launch column and target index from successive random bits. It tracks which enemy-missile slots are in flight and hands the launch request to the missile movement logic over a valid/ready handshake.

---
 rtl/enemy_missile_spawner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/enemy_missile_spawner.sv
// Enemy missile spawner: paces launches on frame ticks, builds column and
// target from the random bit stream, tracks slots, hands off via valid/ready.
module enemy_missile_spawner #(
  parameter int N_SLOTS      = 4,
  parameter int SLOT_W       = 2,
  parameter int X_WIDTH      = 8,
  parameter int X_MAX        = 160,
  parameter int SPAWN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rand_bit,
  input  logic               frame_tick,
  input  logic               game_en,
  input  logic [N_SLOTS-1:0] missile_done,
  output logic               launch_valid,
  input  logic               launch_ready,
  output logic [SLOT_W-1:0]  launch_slot,
  output logic [X_WIDTH-1:0] launch_x,
  output logic [1:0]         launch_target,
  output logic [N_SLOTS-1:0] slot_active,
  output logic [SLOT_W:0]    active_count
);

  localparam int ACC_W = X_WIDTH + 2;
  localparam int CNT_W =
    (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam int BIT_W = $clog2(ACC_W + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST =
    CNT_W'(SPAWN_FRAMES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ACC_W);
  localparam logic [X_WIDTH-1:0] XMAX_V = X_WIDTH'(X_MAX);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WAIT_SLOT,
    LAUNCH
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]   frame_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [ACC_W-1:0]   acc;
  logic [N_SLOTS-1:0] free;
  logic [N_SLOTS-1:0] slot_n;
  logic               free_any;
  logic [SLOT_W-1:0]  free_idx;
  logic [X_WIDTH-1:0] raw;
  logic [X_WIDTH-1:0] x_map;
  logic [SLOT_W:0]    count_n;
  logic               collect_done;
  logic               frame_wrap;
  logic               fire;

  assign collect_done = (state == COLLECT) && (bit_cnt == BIT_LAST);
  assign frame_wrap   = frame_tick && (frame_cnt == FRAME_LAST);
  assign launch_valid = (state == LAUNCH);
  assign fire         = launch_valid && launch_ready && game_en;

  // Fold the out-of-range upper columns back into 0..X_MAX-1
  assign raw   = acc[ACC_W-1:2];
  assign x_map = (raw < XMAX_V) ? raw : raw - XMAX_V;

  // A slot retiring this cycle already counts as free
  always_comb begin
    free     = ~(slot_active & ~missile_done);
    free_any = |free;
    free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) free_idx = SLOT_W'(i);
    end
  end

  always_comb begin
    slot_n = slot_active & ~missile_done;
    if (fire) slot_n[launch_slot] = 1'b1;
    count_n = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      count_n = count_n + (SLOT_W + 1)'(slot_n[i]);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (frame_wrap) state_n = COLLECT;
      end
      COLLECT: begin
        if (collect_done) begin
          state_n = free_any ? LAUNCH : WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (free_any) state_n = LAUNCH;
      end
      LAUNCH: begin
        if (launch_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!game_en) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt     <= '0;
      bit_cnt       <= '0;
      acc           <= '0;
      launch_slot   <= '0;
      launch_x      <= '0;
      launch_target <= '0;
      slot_active   <= '0;
      active_count  <= '0;
    end else begin
      slot_active  <= slot_n;
      active_count <= count_n;
      if (!game_en) begin
        frame_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (frame_wrap) begin
              frame_cnt <= '0;
              bit_cnt   <= '0;
            end else if (frame_tick) begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
          COLLECT: begin
            if (!collect_done) begin
              acc     <= {acc[ACC_W-2:0], rand_bit};
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
              launch_x      <= x_map;
              launch_target <= acc[1:0];
            end
          end
          WAIT_SLOT: begin
          end
          LAUNCH: begin
            if (launch_ready) frame_cnt <= '0;
          end
          default: begin
          end
        endcase
        if (state != LAUNCH && state_n == LAUNCH) begin
          launch_slot <= free_idx;
        end
      end
    end
  end

endmodule
